// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB pipeline register: load funct3 encodings,
// datapath width legality check and the stage control record.
package mem_wb_pkg;

  localparam logic [2:0] F3Lb  = 3'b000;
  localparam logic [2:0] F3Lh  = 3'b001;
  localparam logic [2:0] F3Lw  = 3'b010;
  localparam logic [2:0] F3Ld  = 3'b011;
  localparam logic [2:0] F3Lbu = 3'b100;
  localparam logic [2:0] F3Lhu = 3'b101;
  localparam logic [2:0] F3Lwu = 3'b110;

  typedef struct packed {
    logic valid;
    logic write_en;
    logic mem_read;
  } stage_ctrl_t;

  function automatic bit xlen_legal(int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: selects byte/half/word from the memory word by
// address offset and sign- or zero-extends it according to funct3.
module load_align
  import mem_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] data_in,
  output logic [XLEN-1:0] data_out
);

  logic [2:0]      off;
  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;
  logic [XLEN-1:0] word_sh;

  // A 32-bit datapath has only four byte lanes, so the top offset bit is dropped.
  assign off     = (XLEN == 64) ? offset : {1'b0, offset[1:0]};
  assign byte_sh = data_in >> {off, 3'b000};
  assign half_sh = data_in >> {off[2:1], 4'b0000};
  assign word_sh = data_in >> {off[2], 5'b00000};

  always_comb begin
    data_out = data_in;
    case (funct3)
      F3Lb:    data_out = XLEN'($signed(byte_sh[7:0]));
      F3Lh:    data_out = XLEN'($signed(half_sh[15:0]));
      F3Lw:    data_out = XLEN'($signed(word_sh[31:0]));
      F3Ld:    data_out = data_in;
      F3Lbu:   data_out = XLEN'(byte_sh[7:0]);
      F3Lhu:   data_out = XLEN'(half_sh[15:0]);
      F3Lwu:   data_out = (XLEN == 64) ? XLEN'(word_sh[31:0]) : data_in;
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline register with stall/flush, write-back mux, forwarding port and
// saturating stall counter. Define MEM_WB_LOAD_EXT_EN to format load data on capture.
module mem_wb_pipe
  import mem_wb_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              busywait,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              write_en_in,
  input  logic              mem_read_in,
  input  logic [2:0]        funct3_in,
  input  logic [REG_AW-1:0] write_address_in,
  input  logic [REG_AW-1:0] reg1_read_address_in,
  input  logic [XLEN-1:0]   alu_result_in,
  input  logic [XLEN-1:0]   d_mem_result_in,
  output logic              valid_out,
  output logic              write_en_out,
  output logic              mem_read_out,
  output logic [REG_AW-1:0] write_address_out,
  output logic [REG_AW-1:0] reg1_read_address_out,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [XLEN-1:0]   d_mem_result_out,
  output logic [XLEN-1:0]   wb_data_out,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_addr,
  output logic [XLEN-1:0]   fwd_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  if (!xlen_legal(XLEN)) begin : gen_xlen_check
    $error("mem_wb_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0] load_data;

`ifdef MEM_WB_LOAD_EXT_EN
  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3   (funct3_in),
    .offset   (alu_result_in[2:0]),
    .data_in  (d_mem_result_in),
    .data_out (load_data)
  );
`else
  logic unused_funct3;
  assign unused_funct3 = ^funct3_in;
  assign load_data     = d_mem_result_in;
`endif

  stage_ctrl_t       ctrl_q, ctrl_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [REG_AW-1:0] raddr_q, raddr_d;
  logic [XLEN-1:0]   alu_q, alu_d;
  logic [XLEN-1:0]   dmem_q, dmem_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  always_comb begin
    ctrl_d  = ctrl_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    alu_d   = alu_q;
    dmem_d  = dmem_q;
    stall_d = stall_q;
    // Flush wins over busywait but only kills the flags; data registers hold.
    if (flush) begin
      ctrl_d = '0;
    end else if (!busywait) begin
      ctrl_d.valid    = valid_in;
      ctrl_d.write_en = write_en_in & valid_in & (write_address_in != '0);
      ctrl_d.mem_read = mem_read_in;
      waddr_d         = write_address_in;
      raddr_d         = reg1_read_address_in;
      alu_d           = alu_result_in;
      dmem_d          = load_data;
    end
    if (busywait && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q  <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
      alu_q   <= '0;
      dmem_q  <= '0;
      stall_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      alu_q   <= alu_d;
      dmem_q  <= dmem_d;
      stall_q <= stall_d;
    end
  end

  assign valid_out             = ctrl_q.valid;
  assign write_en_out          = ctrl_q.write_en;
  assign mem_read_out          = ctrl_q.mem_read;
  assign write_address_out     = waddr_q;
  assign reg1_read_address_out = raddr_q;
  assign alu_result_out        = alu_q;
  assign d_mem_result_out      = dmem_q;
  assign wb_data_out           = ctrl_q.mem_read ? dmem_q : alu_q;
  assign fwd_valid             = ctrl_q.valid & ctrl_q.write_en;
  assign fwd_addr              = waddr_q;
  assign fwd_data              = wb_data_out;
  assign stall_cycles          = stall_q;

endmodule
